id_stage_pipe: RTL
==================

# id_stage_pipe

Pipelined, parametrised instruction-decode stage for the five-stage RV32I core. It extends the single-cycle decode path (immediate extension, register-file read, write-back select) with an ID/EX pipeline register, operand forwarding from MEM and WB, load-use stall detection and branch flush. It sits between the IF/ID register and the EX stage. The WB stage drives its register-file write port.

## Interface
Parameters:
- DATA_W, 32: datapath width; immediates sign-extend to DATA_W.
- REG_AW, 5: register address width; 2^REG_AW registers, x0 hard-wired to 0.
- RF_BYPASS, 1: when 1, a read of the register being written by WB in the same cycle returns the new data.

Ports:
- cpu_clk  in  1  stage clock, rising edge.
- cpu_rst  in  1  asynchronous, active-low reset.
- if_valid  in  1  IF/ID holds a valid instruction.
- if_inst  in  32  instruction word.
- if_pc, if_pc4  in  DATA_W  PC and PC+4 of the instruction.
- id_sext_op  in  3  immediate format, encodings from shared defines.
- id_rf_we, id_mem_rd  in  1  decoded: writes rd / is a load.
- id_wd_sel  in  2  decoded write-back select.
- id_use_rs1, id_use_rs2  in  1  decoded: instruction reads rs1/rs2.
- ex_flush  in  1  branch/jump taken in EX; kill the instruction entering EX.
- mem_we  in  1  MEM-stage instruction writes rd.
- mem_wr  in  REG_AW  its destination register.
- mem_wd  in  DATA_W  its result.
- wb_we  in  1  WB-stage instruction writes rd.
- wb_wr  in  REG_AW  its destination register.
- wb_sel  in  2  WB write-data select.
- wb_alu_c, wb_dram_rd, wb_pc4, wb_ext  in  DATA_W  WB write-data candidates.
- id_stall  out  1  hold PC and IF/ID this cycle (combinational).
- idex_valid  out  1  ID/EX holds a valid instruction.
- idex_pc, idex_pc4, idex_rd1, idex_rd2, idex_ext  out  DATA_W  registered operands.
- idex_wr  out  REG_AW  registered destination register.
- idex_rf_we, idex_mem_rd  out  1  registered controls.
- idex_wd_sel  out  2  registered control.

## Operation
- Field extraction: rs1 = inst[19:15], rs2 = inst[24:20] and rd = inst[11:7], truncated or zero-extended to REG_AW.
- WB write data: a 4:1 mux on wb_sel over ALU_C, DRAM_RD, NPC_PC4 and SEXT_EXT. Undefined encodings select wb_alu_c.
- RF write condition: wb_we && wb_wr != 0. Writes to x0 are discarded.
- Operand resolution, per source operand in priority order:
  - source register is x0: result is 0;
  - mem_we && mem_wr == src: result is mem_wd;
  - wb_we && wb_wr == src: result is the WB write data;
  - otherwise: RF read.
- Load-use hazard: asserted when all of the following hold:
  - idex_valid && idex_mem_rd && idex_rf_we && idex_wr != 0;
  - (id_use_rs1 && rs1 == idex_wr) || (id_use_rs2 && rs2 == idex_wr);
  - if_valid.
- id_stall = hazard && !ex_flush.
- ID/EX update at every rising edge, in priority order:
  - ex_flush: idex_valid ← 0; all other fields ← 0.
  - hazard: bubble; idex_valid ← 0 and idex_rf_we ← 0, idex_mem_rd ← 0. The data fields are don't-care and hold 0.
  - otherwise: idex_valid ← if_valid and every field loads from ID. idex_rf_we ← id_rf_we && if_valid, so an invalid slot never writes.
- An invalid slot never matches for hazard purposes.

## Timing
- Reset (cpu_rst low, async): every idex_* output is 0 and all RF entries are 0. id_stall is 0 because idex_valid is 0.
- Latency: one cycle from if_* to idex_*.
- RF write is synchronous on cpu_clk. Same-cycle read-during-write behaviour:
  - RF_BYPASS=1: returns the new value. The forwarding path already covers this; the bypass guards the case where WB forwarding is disabled.
  - RF_BYPASS=0: returns the old value.
- A load-use hazard produces exactly one bubble cycle. On the next cycle the load has moved to MEM and its data reaches ID through mem_wd.
- Simultaneous ex_flush and hazard: the flush wins and id_stall is 0. IF redirects, so the IF/ID contents are dead.
- Reset mid-stream clears ID/EX immediately, without waiting for a clock edge.

## Structure
- Shared defines: wd_sel encodings (ALU_C, DRAM_RD, NPC_PC4, SEXT_EXT) and sext_op encodings; these are reused by the controller and WB.
- Sub-module rf_param (parameters DATA_W, REG_AW, RF_BYPASS): two asynchronous read ports, one synchronous write port, x0 forced to 0, async active-low clear.
- Immediate extension reuses SEXT, widened to DATA_W by sign-replicating bit 31.

## Test plan
- Reset: hold cpu_rst low with if_valid=1. Required: idex_valid=0, idex_rd1=0, id_stall=0. After release, a read of x5 returns 0.
- Write then read: WB writes x3=0xDEADBEEF. Next cycle `add x4,x3,x0` → idex_rd1=0xDEADBEEF.
- Forward priority: mem_wr=wb_wr=7, mem_wd=0x11, WB data=0x22, instruction reads x7 → idex_rd1=0x11. Repeat with mem_we=0 → 0x22.
- x0 guard: mem_we=1, mem_wr=0, mem_wd=0x55, instruction reads x0 → operand is 0. A WB write to x0 leaves x0 reading 0.
- Load-use: `lw x9` in ID/EX, then `add x1,x9,x2`. Required: id_stall=1 for one cycle with a bubble (idex_valid=0). Next cycle, with mem_wd=0x99, idex_rd1=0x99.
- Flush versus hazard: the load-use condition is present and ex_flush=1 in the same cycle. Required: id_stall=0 and idex_valid=0 next cycle.

Source files
------------

// File: rtl/id_stage_pipe_pkg.sv
// rtl/id_stage_pipe_pkg.sv - shared write-back select and immediate format encodings
package id_stage_pipe_pkg;

    typedef enum logic [1:0] {
        WD_ALU_C    = 2'd0,
        WD_DRAM_RD  = 2'd1,
        WD_NPC_PC4  = 2'd2,
        WD_SEXT_EXT = 2'd3
    } wd_sel_e;

    typedef enum logic [2:0] {
        SEXT_I = 3'd0,
        SEXT_S = 3'd1,
        SEXT_B = 3'd2,
        SEXT_U = 3'd3,
        SEXT_J = 3'd4
    } sext_op_e;

    // RV32I immediate extension; always produces the 32-bit architectural form
    function automatic logic [31:0] sext32(input logic [2:0] op, input logic [31:0] inst);
        logic [31:0] imm;
        imm = '0;
        case (op)
            SEXT_I:  imm = {{20{inst[31]}}, inst[31:20]};
            SEXT_S:  imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            SEXT_B:  imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            SEXT_U:  imm = {inst[31:12], 12'b0};
            SEXT_J:  imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default: imm = '0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/id_stage_pipe_rf_param.sv
// rtl/id_stage_pipe_rf_param.sv - 2R1W register file, x0 hard-wired to zero
module rf_param #(
    parameter int DATA_W    = 32,
    parameter int REG_AW    = 5,
    parameter int RF_BYPASS = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] ra1,
    input  logic [REG_AW-1:0] ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    input  logic              we,
    input  logic [REG_AW-1:0] wa,
    input  logic [DATA_W-1:0] wd
);

    localparam int NREG = 1 << REG_AW;

    logic [DATA_W-1:0] regs [NREG];
    logic              wr_en;

    assign wr_en = we && (wa != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (wr_en) begin
            regs[wa] <= wd;
        end
    end

    always_comb begin
        rd1 = '0;
        rd2 = '0;
        if (ra1 != '0) rd1 = (RF_BYPASS != 0 && wr_en && wa == ra1) ? wd : regs[ra1];
        if (ra2 != '0) rd2 = (RF_BYPASS != 0 && wr_en && wa == ra2) ? wd : regs[ra2];
    end

endmodule

// File: rtl/id_stage_pipe.sv
// rtl/id_stage_pipe.sv - RV32I decode stage with forwarding, load-use stall, flush and ID/EX register
module id_stage_pipe
    import id_stage_pipe_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int REG_AW    = 5,
    parameter int RF_BYPASS = 1
) (
    input  logic              cpu_clk,
    input  logic              cpu_rst,
    input  logic              if_valid,
    input  logic [31:0]       if_inst,
    input  logic [DATA_W-1:0] if_pc,
    input  logic [DATA_W-1:0] if_pc4,
    input  logic [2:0]        id_sext_op,
    input  logic              id_rf_we,
    input  logic              id_mem_rd,
    input  logic [1:0]        id_wd_sel,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic              ex_flush,
    input  logic              mem_we,
    input  logic [REG_AW-1:0] mem_wr,
    input  logic [DATA_W-1:0] mem_wd,
    input  logic              wb_we,
    input  logic [REG_AW-1:0] wb_wr,
    input  logic [1:0]        wb_sel,
    input  logic [DATA_W-1:0] wb_alu_c,
    input  logic [DATA_W-1:0] wb_dram_rd,
    input  logic [DATA_W-1:0] wb_pc4,
    input  logic [DATA_W-1:0] wb_ext,
    output logic              id_stall,
    output logic              idex_valid,
    output logic [DATA_W-1:0] idex_pc,
    output logic [DATA_W-1:0] idex_pc4,
    output logic [DATA_W-1:0] idex_rd1,
    output logic [DATA_W-1:0] idex_rd2,
    output logic [DATA_W-1:0] idex_ext,
    output logic [REG_AW-1:0] idex_wr,
    output logic              idex_rf_we,
    output logic              idex_mem_rd,
    output logic [1:0]        idex_wd_sel
);

    logic [REG_AW-1:0] rs1, rs2, rd;
    logic [DATA_W-1:0] wb_wd, rf_rd1, rf_rd2, op1, op2, ext;
    logic signed [31:0] ext32;
    logic              hazard;
    logic              unused_opcode;

    assign rs1 = REG_AW'(if_inst[19:15]);
    assign rs2 = REG_AW'(if_inst[24:20]);
    assign rd  = REG_AW'(if_inst[11:7]);
    assign unused_opcode = ^if_inst[6:0];

    assign ext32 = sext32(id_sext_op, if_inst);
    assign ext   = DATA_W'(ext32);

    always_comb begin
        wb_wd = wb_alu_c;
        case (wb_sel)
            WD_DRAM_RD:  wb_wd = wb_dram_rd;
            WD_NPC_PC4:  wb_wd = wb_pc4;
            WD_SEXT_EXT: wb_wd = wb_ext;
            default:     wb_wd = wb_alu_c;
        endcase
    end

    rf_param #(
        .DATA_W   (DATA_W),
        .REG_AW   (REG_AW),
        .RF_BYPASS(RF_BYPASS)
    ) u_rf (
        .clk  (cpu_clk),
        .rst_n(cpu_rst),
        .ra1  (rs1),
        .ra2  (rs2),
        .rd1  (rf_rd1),
        .rd2  (rf_rd2),
        .we   (wb_we),
        .wa   (wb_wr),
        .wd   (wb_wd)
    );

    // MEM is younger than WB, so it wins when both target the same register
    always_comb begin
        op1 = rf_rd1;
        if (rs1 == '0)                      op1 = '0;
        else if (mem_we && mem_wr == rs1)   op1 = mem_wd;
        else if (wb_we && wb_wr == rs1)     op1 = wb_wd;
    end

    always_comb begin
        op2 = rf_rd2;
        if (rs2 == '0)                      op2 = '0;
        else if (mem_we && mem_wr == rs2)   op2 = mem_wd;
        else if (wb_we && wb_wr == rs2)     op2 = wb_wd;
    end

    assign hazard = idex_valid && idex_mem_rd && idex_rf_we && (idex_wr != '0) && if_valid &&
                    ((id_use_rs1 && rs1 == idex_wr) || (id_use_rs2 && rs2 == idex_wr));

    assign id_stall = hazard && !ex_flush;

    // Flush and bubble both leave an all-zero slot
    always_ff @(posedge cpu_clk or negedge cpu_rst) begin
        if (!cpu_rst || ex_flush || hazard) begin
            idex_valid  <= 1'b0;
            idex_pc     <= '0;
            idex_pc4    <= '0;
            idex_rd1    <= '0;
            idex_rd2    <= '0;
            idex_ext    <= '0;
            idex_wr     <= '0;
            idex_rf_we  <= 1'b0;
            idex_mem_rd <= 1'b0;
            idex_wd_sel <= '0;
        end else begin
            idex_valid  <= if_valid;
            idex_pc     <= if_pc;
            idex_pc4    <= if_pc4;
            idex_rd1    <= op1;
            idex_rd2    <= op2;
            idex_ext    <= ext;
            idex_wr     <= rd;
            idex_rf_we  <= id_rf_we && if_valid;
            idex_mem_rd <= id_mem_rd;
            idex_wd_sel <= id_wd_sel;
        end
    end

endmodule
